// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen/sprite geometry, colours and blitter state encoding
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 16;

  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_BLACK = 3'b000;

  // Vertical start position: sprite roughly centred on the 120-line screen
  localparam logic [6:0] PY_START = 7'd52;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    ERASE = 2'd1,
    MOVE  = 2'd2,
    DRAW  = 2'd3
  } state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - frame-rate delay counter and frame divider producing the motion step pulse
module frame_tick_gen #(
  parameter int TICK_CYCLES     = 833334,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic enable,
  output logic step
);

  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int FW = $clog2(FRAMES_PER_STEP + 1);

  logic [TW-1:0] tick_cnt;
  logic [FW-1:0] frame_cnt;

  // Count clocks into frames and frames into steps; both counters freeze while motion is disabled
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt  <= '0;
      frame_cnt <= '0;
      step      <= 1'b0;
    end else begin
      step <= 1'b0;
      if (enable) begin
        if (tick_cnt == TW'(TICK_CYCLES - 1)) begin
          tick_cnt <= '0;
          if (frame_cnt == FW'(FRAMES_PER_STEP - 1)) begin
            frame_cnt <= '0;
            step      <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + FW'(1);
          end
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - bouncing sprite: erase old box, move, redraw from ROM, one pixel per clock
module sprite_blitter #(
  parameter int SPRITE_W        = vga_pkg::SPRITE_W,
  parameter int SPRITE_H        = vga_pkg::SPRITE_H,
  parameter int SCREEN_W        = vga_pkg::SCREEN_W,
  parameter int SCREEN_H        = vga_pkg::SCREEN_H,
  parameter int TICK_CYCLES     = 833334,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic                                  CLOCK_50,
  input  logic                                  reset_n,
  input  logic                                  enable,
  output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]  rom_addr,
  input  logic                                  rom_q,
  output logic [7:0]                            x,
  output logic [6:0]                            y,
  output logic [2:0]                            colour,
  output logic                                  plot,
  output logic                                  busy
);

  import vga_pkg::*;

  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);
  localparam int AW    = COL_W + ROW_W;
  localparam int NPIX  = SPRITE_W * SPRITE_H;

  localparam logic [7:0]  PX_MAX = 8'(SCREEN_W - SPRITE_W);
  localparam logic [6:0]  PY_MAX = 7'(SCREEN_H - SPRITE_H);
  localparam logic [AW:0] LAST   = (AW+1)'(NPIX);

  state_t           state;
  state_t           state_next;
  logic             step;
  logic [7:0]       px;
  logic [6:0]       py;
  logic             dir_x;
  logic             dir_y;
  logic             drawn;
  logic [AW:0]      cnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             scan_done;
  logic             from_rom;

  frame_tick_gen #(
    .TICK_CYCLES     (TICK_CYCLES),
    .FRAMES_PER_STEP (FRAMES_PER_STEP)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .enable   (enable),
    .step     (step)
  );

  // The scan counter is one wider than the box so the extra terminal count marks the flush/last cycle
  assign col       = cnt[COL_W-1:0];
  assign row       = cnt[AW-1:COL_W];
  assign scan_done = (cnt == LAST);
  assign rom_addr  = cnt[AW-1:0];
  assign busy      = (state != WAIT);
  // rom_q is itself registered in the ROM, so it lines up with the registered x/y/plot of the same pixel
  assign colour    = (from_rom && rom_q) ? COL_WHITE : COL_BLACK;

  // FSM state register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= WAIT;
    else          state <= state_next;
  end

  // Next-state logic: steps are only honoured in WAIT, everything else runs to completion
  always_comb begin
    state_next = state;
    case (state)
      WAIT:    if (step) state_next = drawn ? ERASE : MOVE;
      ERASE:   if (scan_done) state_next = MOVE;
      MOVE:    state_next = DRAW;
      DRAW:    if (scan_done) state_next = WAIT;
      default: state_next = WAIT;
    endcase
  end

  // Position/direction, scan counter and registered pixel outputs
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      px       <= '0;
      py       <= PY_START;
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      drawn    <= 1'b0;
      cnt      <= '0;
      x        <= '0;
      y        <= '0;
      plot     <= 1'b0;
      from_rom <= 1'b0;
    end else begin
      plot     <= 1'b0;
      from_rom <= 1'b0;
      case (state)
        WAIT: begin
          cnt <= '0;
          // Emit the first erase pixel on the same edge that enters ERASE
          if (step && drawn) begin
            x    <= px;
            y    <= py;
            plot <= 1'b1;
            cnt  <= (AW+1)'(1);
          end
        end
        ERASE: begin
          if (scan_done) begin
            cnt <= '0;
          end else begin
            x    <= px + 8'(col);
            y    <= py + 7'(row);
            plot <= 1'b1;
            cnt  <= cnt + (AW+1)'(1);
          end
        end
        MOVE: begin
          cnt <= '0;
          if (dir_x && px == PX_MAX) begin
            dir_x <= 1'b0;
            px    <= PX_MAX - 8'(1);
          end else if (!dir_x && px == '0) begin
            dir_x <= 1'b1;
            px    <= 8'(1);
          end else begin
            px <= dir_x ? px + 8'(1) : px - 8'(1);
          end
          if (dir_y && py == PY_MAX) begin
            dir_y <= 1'b0;
            py    <= PY_MAX - 7'(1);
          end else if (!dir_y && py == '0) begin
            dir_y <= 1'b1;
            py    <= 7'(1);
          end else begin
            py <= dir_y ? py + 7'(1) : py - 7'(1);
          end
        end
        DRAW: begin
          // Coordinates trail rom_addr by one cycle; the terminal count is the flush of the last pixel
          if (scan_done) begin
            cnt   <= '0;
            drawn <= 1'b1;
          end else begin
            x        <= px + 8'(col);
            y        <= py + 7'(row);
            plot     <= 1'b1;
            from_rom <= 1'b1;
            cnt      <= cnt + (AW+1)'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - directed/randomised self-checking bench for sprite_blitter with a motion/pixel model
module tb_sprite_blitter;

  logic       CLOCK_50;
  logic       reset_n;
  logic       enable;
  logic [7:0] rom_addr;
  logic       rom_q;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;

  int vectors;
  int miscompares;

  bit sprite [256];

  int  mpx, mpy, mdx, mdy;
  bit  mdrawn;

  typedef struct {
    bit p;
    int x;
    int y;
    int c;
  } pix_t;

  sprite_blitter #(
    .TICK_CYCLES     (4),
    .FRAMES_PER_STEP (1)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .enable   (enable),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  // Synchronous sprite ROM: data one clock after the address
  always @(posedge CLOCK_50) rom_q <= sprite[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounce rule: a step that would leave [0, maxv] reflects the direction instead
  function automatic void step_axis(inout int p, inout int d, input int maxv);
    int n;
    n = p + d;
    if (n < 0 || n > maxv) begin
      d = -d;
      n = p + d;
    end
    p = n;
  endfunction

  function automatic void model_reset();
    mpx = 0; mpy = 52; mdx = 1; mdy = 1; mdrawn = 0;
  endfunction

  task automatic randomize_sprite();
    for (int i = 0; i < 256; i++) sprite[i] = 1'($urandom_range(0, 1));
  endtask

  // One motion step end to end; drop_at/reset_at are busy-cycle indices for mid-operation events
  task automatic run_txn(input string tag, input int drop_at, input int reset_at);
    pix_t q[$];
    pix_t e;
    int   n;
    int   ox, oy;
    bit   erase;
    erase = mdrawn;
    ox = mpx;
    oy = mpy;
    if (erase)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) begin
          e = '{1'b1, ox + c, oy + r, 0};
          q.push_back(e);
        end
    e = '{1'b0, 0, 0, 0};
    q.push_back(e);
    step_axis(mpx, mdx, 144);
    step_axis(mpy, mdy, 104);
    q.push_back(e);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        e = '{1'b1, mpx + c, mpy + r, sprite[r*16 + c] ? 7 : 0};
        q.push_back(e);
      end

    n = 0;
    while (busy !== 1'b1 && n < 64) begin
      @(negedge CLOCK_50);
      n++;
    end
    check({tag, "_start"}, 32'(busy), 32'd1);

    n = 0;
    while (busy === 1'b1 && n < 600) begin
      if (n < q.size()) begin
        if (q[n].p)
          check({tag, "_pix"}, {busy, plot, x, y, colour},
                {1'b1, 1'b1, 8'(q[n].x), 7'(q[n].y), 3'(q[n].c)});
        else
          check({tag, "_gap"}, {busy, plot}, 2'b10);
      end
      if (n == drop_at) enable = 1'b0;
      if (n == reset_at) begin
        reset_n = 1'b0;
        #1;
        check({tag, "_async_reset"}, {plot, busy, colour}, 5'b0);
        #4;
        reset_n = 1'b1;
        model_reset();
        return;
      end
      @(negedge CLOCK_50);
      n++;
    end
    check({tag, "_step_to_idle"}, n + 1, erase ? 515 : 259);
    mdrawn = 1;
  endtask

  task automatic preload(input int px0, input int py0, input bit dx0, input bit dy0);
    force dut.px    = 8'(px0);
    force dut.py    = 7'(py0);
    force dut.dir_x = dx0;
    force dut.dir_y = dy0;
    #1;
    release dut.px;
    release dut.py;
    release dut.dir_x;
    release dut.dir_y;
    mpx = px0;
    mpy = py0;
    mdx = dx0 ? 1 : -1;
    mdy = dy0 ? 1 : -1;
  endtask

  initial begin
    int idle_busy;
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    enable      = 1'b1;
    for (int i = 0; i < 256; i++) sprite[i] = i[0];

    repeat (3) @(negedge CLOCK_50);
    check("reset_outputs", {rom_addr, x, y, colour, plot, busy}, 28'd0);
    reset_n = 1'b1;
    model_reset();

    // First step: no erase, odd columns white
    run_txn("t1_first", -1, -1);
    randomize_sprite();
    run_txn("t2_erase", -1, -1);

    // Enable falls at draw pixel 100: draw completes, then motion stops
    randomize_sprite();
    run_txn("t3_drop", 256 + 2 + 100, -1);
    idle_busy = 0;
    repeat (40) begin
      @(negedge CLOCK_50);
      if (busy === 1'b1) idle_busy++;
    end
    check("disabled_idle", idle_busy, 0);
    enable = 1'b1;
    run_txn("t4_resume", -1, -1);

    // Bounce at the far corner
    run_txn("t5_prep", 256 + 2 + 20, -1);
    preload(144, 104, 1'b1, 1'b1);
    enable = 1'b1;
    run_txn("t6_max_edge", -1, -1);
    run_txn("t7_after_max", -1, -1);

    // Bounce at the origin
    run_txn("t8_prep", 256 + 2 + 20, -1);
    preload(0, 0, 1'b0, 1'b0);
    enable = 1'b1;
    randomize_sprite();
    run_txn("t9_min_edge", -1, -1);
    run_txn("t10_after_min", -1, -1);

    // Reset at erase pixel 50, then the next step skips erase from (0,52)
    run_txn("t11_reset", -1, 50);
    randomize_sprite();
    run_txn("t12_after_reset", -1, -1);

    for (int k = 0; k < 3; k++) begin
      randomize_sprite();
      run_txn("t_rand", -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Upstream pixel-generation stage for the 160x120 monochrome VGA path. It moves a 16x16 sprite across the screen with bounce-at-edge motion. On every motion step it erases the sprite at its old position, then redraws it from the sprite ROM at the new position. It drives the `x`/`y`/`colour`/`plot` write port of `vga_adapter` one pixel per clock.

## Interface
Parameters:
- SPRITE_W, 16, sprite width in pixels (power of two)
- SPRITE_H, 16, sprite height in pixels (power of two)
- SCREEN_W, 160, frame width
- SCREEN_H, 120, frame height
- TICK_CYCLES, 833334, CLOCK_50 cycles per 60 Hz frame tick; benches override to a small value
- FRAMES_PER_STEP, 4, frame ticks per motion step

Ports:
- CLOCK_50  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  motion enable (SW[9])
- rom_addr  out  8  sprite ROM address, row-major, {row[3:0], col[3:0]}
- rom_q  in  1  ROM data; synchronous, valid exactly one cycle after rom_addr
- x  out  8  pixel column to vga_adapter
- y  out  7  pixel row to vga_adapter
- colour  out  3  pixel colour: 3'b111 or 3'b000
- plot  out  1  write strobe to vga_adapter
- busy  out  1  high in ERASE, MOVE and DRAW

## Operation
- Position register `(px, py)` marks the sprite top-left. Legal range: px 0..SCREEN_W-SPRITE_W (0..144), py 0..SCREEN_H-SPRITE_H (0..104).
- Reset values: px=0, py=52, dir_x=+1, dir_y=+1, drawn=0, state=WAIT, all outputs 0.
- frame_tick_gen pulses `step` for one cycle every TICK_CYCLES*FRAMES_PER_STEP cycles. The counter runs only while enable=1 and holds its value while enable=0.
- FSM states:
  - WAIT: outputs idle. On `step`: go to ERASE if drawn=1, else to MOVE.
  - ERASE: scan a SPRITE_W x SPRITE_H box at (px,py), col fastest. Each cycle plot=1, colour=000. After the last pixel, go to MOVE.
  - MOVE: one cycle, position update per axis.
    - If dir=+1 and pos==max: dir becomes -1 and pos becomes max-1.
    - If dir=-1 and pos==0: dir becomes +1 and pos becomes 1.
    - Otherwise pos advances by dir.
    - Then go to DRAW.
  - DRAW: issue rom_addr for each pixel in row-major order. The pixel coordinate is pipelined one stage to align with rom_q.
    - Output is x=px+col, y=py+row, plot=1, colour = rom_q ? 111 : 000.
    - After the last address, one flush cycle emits the final pixel. Then drawn=1 and the FSM goes to WAIT.
- A `step` arriving in any state other than WAIT is dropped. There is no queueing.
- enable falling mid-operation does not abort. The current ERASE/DRAW completes, and the FSM then stays in WAIT.
- Arithmetic:
  - x, y sums are zero-extended and never exceed 159 and 119.
  - Position compares use the full register width; there is no wrap-around.

## Timing
- ERASE: 256 cycles, plot=1 on every cycle.
- MOVE: 1 cycle, plot=0.
- DRAW: 257 cycles. The first cycle is address-only with plot=0. plot=1 on the following 256 cycles.
- Step to first plotted pixel: 1 cycle (WAIT→ERASE registered). Step to busy deassertion: 515 cycles with erase, 259 cycles without.
- x, y, colour and plot are registered outputs that change together.
- A reset assertion at any time forces plot=0, busy=0, the FSM to WAIT and position/direction to their reset values, asynchronously. The screen is not cleared, and the first step after reset skips ERASE.

## Structure
- Shared package `vga_pkg`: SCREEN_W, SCREEN_H, SPRITE_W, SPRITE_H, colour constants COL_WHITE=3'b111 and COL_BLACK=3'b000, and the FSM state enum {WAIT, ERASE, MOVE, DRAW}.
- Sub-module `frame_tick_gen`: the 60 Hz delay counter plus the frame divider, producing the one-cycle `step`.
- The top level contains the FSM, the position/direction registers, the scan counters and the one-stage output pipeline. The ROM is instantiated outside this block.

## Test plan
- Reset, enable=1, TICK_CYCLES=4, FRAMES_PER_STEP=1.
  - The first step skips ERASE, moves to (1,53), and DRAW plots 256 pixels spanning x 1..16, y 53..68.
  - busy is high for 259 cycles.
- ROM model returning col[0]: DRAW emits colour 111 exactly at odd columns.
  - The first plotted pixel is (px,py); the last is (px+15,py+15).
  - The 1-cycle ROM latency is honoured.
- Second step: ERASE plots 256 black pixels at the previous position before MOVE.
  - Total busy time is 515 cycles.
- Preload px=144, dir_x=+1, py=104, dir_y=+1, then step.
  - Required result: (143,103), both directions -1.
  - Symmetric check from (0,0) with dir -1: result is (1,1).
- enable dropped at DRAW pixel 100: the draw completes all 256 pixels, then no further steps occur for 10×step period.
  - Re-raising enable resumes motion.
- reset_n pulsed low at ERASE pixel 50: plot=0 immediately and position returns to (0,52).
  - The next step goes WAIT→MOVE with no erase.
